// File: rtl/brain_m_sched_pkg.sv
// Shared types and helpers for the brain_m core scheduler.
package brain_m_sched_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, REST} state_t;

  localparam int DW_DEFAULT = 7;
  localparam int SHAPE_W    = 5;
  localparam int STAT_W     = 8;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/brain_m_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at NCH.
module brain_m_rr_arb #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);

  int best_d;
  int d;

  // The winner is the requester with the smallest forward distance from ptr.
  always_comb begin
    best_d = NCH;
    d      = 0;
    idx    = '0;
    for (int j = 0; j < NCH; j++) begin
      d = (j - int'(ptr) + NCH) % NCH;
      if (req[j] && d < best_d) begin
        best_d = d;
        idx    = IW'(j);
      end
    end
  end

  assign any = |req;

  always_comb begin
    gnt = '0;
    for (int j = 0; j < NCH; j++) begin
      gnt[j] = any && (idx == IW'(j));
    end
  end

endmodule

// File: rtl/brain_m_scheduler.sv
// Time-shares one brain_m core between NCH sensor channels (round-robin, start/E sequencing).
// Optional per-channel statistics counters: define BRAIN_M_SCHED_STATS_EN.
module brain_m_scheduler
  import brain_m_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int DWELL   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      req,
  input  logic [NCH*DW-1:0]   dist_in,
  input  logic [NCH-1:0]      mode_in,
  output logic [NCH-1:0]      grant,
  output logic [NCH-1:0]      done,
  output logic                res_color,
  output logic [SHAPE_W-1:0]  res_shape,
  output logic                timeout_err,
  output logic [DW-1:0]       bm_dist,
  output logic                bm_mode,
  output logic                bm_start,
  output logic                bm_E,
  input  logic                bm_color,
  input  logic                bm_OE,
  input  logic [SHAPE_W-1:0]  bm_shape,
  input  logic [2:0]          stat_sel,
  output logic [15:0]         stat_cnt
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         state, state_nxt;
  logic [7:0]     cnt;
  logic [IW-1:0]  ptr, idx, arb_idx;
  logic [NCH-1:0] arb_gnt;
  logic           arb_any;
  logic           req_cur, mode_cur;
  logic [DW-1:0]  dist_cur;
  logic           wait_live, hit, tmo;

  brain_m_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    req_cur  = 1'b0;
    mode_cur = 1'b0;
    dist_cur = '0;
    for (int j = 0; j < NCH; j++) begin
      if (idx == IW'(j)) begin
        req_cur  = req[j];
        mode_cur = mode_in[j];
        dist_cur = dist_in[j*DW +: DW];
      end
    end
  end

  assign wait_live = (state == WAIT) && req_cur;
  assign hit       = wait_live && bm_OE;
  assign tmo       = wait_live && !bm_OE && (cnt == 8'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Withdrawal of the owner's request overrides every other exit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_any) state_nxt = LOAD;
      LOAD: state_nxt = req_cur ? RUN : REST;
      RUN: begin
        if (!req_cur)                      state_nxt = REST;
        else if (cnt == 8'(DWELL-1))       state_nxt = WAIT;
      end
      WAIT: if (!req_cur || hit || tmo)    state_nxt = REST;
      REST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bm_start = (state == RUN);
    bm_E     = (state == RUN) || (state == WAIT);
  end

  // One counter serves both the dwell and the OE timeout; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      idx         <= '0;
      ptr         <= '0;
      bm_dist     <= '0;
      bm_mode     <= 1'b0;
      done        <= '0;
      timeout_err <= 1'b0;
      res_color   <= 1'b0;
      res_shape   <= '0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      if (state == IDLE && arb_any) begin
        grant <= arb_gnt;
        idx   <= arb_idx;
      end
      if ((state == LOAD || state == RUN) && req_cur) begin
        bm_dist <= dist_cur;
        bm_mode <= mode_cur;
      end
      if (state == LOAD) ptr <= (idx == IW'(NCH-1)) ? '0 : idx + 1'b1;
      if (state_nxt == REST) grant <= '0;
      if (hit) begin
        done      <= grant;
        res_color <= bm_color;
        res_shape <= bm_shape;
      end
      if (tmo) timeout_err <= 1'b1;
    end
  end

`ifdef BRAIN_M_SCHED_STATS_EN
  logic [STAT_W-1:0] comp_cnt [NCH];
  logic [STAT_W-1:0] tmo_cnt  [NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NCH; j++) begin
        comp_cnt[j] <= '0;
        tmo_cnt[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (idx == IW'(j)) begin
          if (hit) comp_cnt[j] <= sat_inc(comp_cnt[j]);
          if (tmo) tmo_cnt[j]  <= sat_inc(tmo_cnt[j]);
        end
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int j = 0; j < NCH; j++) begin
      if (stat_sel == 3'(j)) stat_cnt = {tmo_cnt[j], comp_cnt[j]};
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_brain_m_scheduler.sv
// Scoreboard bench for brain_m_scheduler with a behavioural brain_m core stub.
module tb_brain_m_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] dist_in;
  logic [NCH-1:0]    mode_in;
  logic [NCH-1:0]    grant, done;
  logic              res_color, timeout_err;
  logic [4:0]        res_shape;
  logic [DW-1:0]     bm_dist;
  logic              bm_mode, bm_start, bm_E;
  logic              bm_color, bm_OE;
  logic [4:0]        bm_shape;
  logic [2:0]        stat_sel;
  logic [15:0]       stat_cnt;

  always #5 clk = ~clk;

  brain_m_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dist_in(dist_in), .mode_in(mode_in),
    .grant(grant), .done(done), .res_color(res_color), .res_shape(res_shape),
    .timeout_err(timeout_err), .bm_dist(bm_dist), .bm_mode(bm_mode),
    .bm_start(bm_start), .bm_E(bm_E), .bm_color(bm_color), .bm_OE(bm_OE),
    .bm_shape(bm_shape), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  typedef struct {
    bit       tmo;
    int       ch;
    bit       color;
    bit [4:0] shape;
  } exp_t;

  exp_t           sb[$];
  int             errors = 0;
  int             checks = 0;
  int             mptr = 0;
  int             oe_delay = 0;
  int             cd = -1;
  bit             prev_start = 0;
  logic           oe_q = 1'b0;
  logic [NCH-1:0] last_g = '0;
  exp_t           last_done;

  // The core's answer is a fixed function of what it was fed.
  function automatic bit f_color(logic [6:0] d, logic m);
    return ^{d, m};
  endfunction

  function automatic logic [4:0] f_shape(logic [6:0] d, logic m);
    return d[4:0] ^ {m, 4'b1010};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Round-robin reference: first requester at or after the model pointer.
  function automatic int pick(logic [3:0] mask);
    int w;
    w = -1;
    for (int i = 0; i < NCH; i++) begin
      if (w < 0 && mask[(mptr + i) % NCH]) w = (mptr + i) % NCH;
    end
    mptr = (w + 1) % NCH;
    return w;
  endfunction

  function automatic exp_t mk(bit t, int ch);
    exp_t e;
    logic [6:0] d;
    d       = dist_in[ch*DW +: DW];
    e.tmo   = t;
    e.ch    = ch;
    e.color = f_color(d, mode_in[ch]);
    e.shape = f_shape(d, mode_in[ch]);
    return e;
  endfunction

  // brain_m stub: OE pulses oe_delay cycles after start falls (never if negative).
  initial begin
    bm_OE = 1'b0; bm_color = 1'b0; bm_shape = '0;
    forever begin
      @(negedge clk);
      bm_OE = 1'b0;
      if (!rst_n) cd = -1;
      else if (prev_start && !bm_start && bm_E && oe_delay >= 0) cd = oe_delay;
      if (cd == 0) begin
        bm_OE    = 1'b1;
        bm_color = f_color(bm_dist, bm_mode);
        bm_shape = f_shape(bm_dist, bm_mode);
        cd       = -1;
      end else if (cd > 0) begin
        cd--;
      end
      prev_start = bm_start;
    end
  end

  initial forever begin
    @(posedge clk);
    oe_q = bm_OE;
  end

  // Monitor: every done/timeout_err must match the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (grant != 0) last_g = grant;
    if (rst_n && (done != 0 || timeout_err)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: done=%b timeout_err=%b with nothing expected", done, timeout_err);
      end else begin
        e = sb.pop_front();
        if (e.tmo) begin
          chk("tmo_flag", 32'(timeout_err), 1);
          chk("tmo_done", 32'(done), 0);
          chk("tmo_chan", 32'(last_g), 32'(1) << e.ch);
        end else begin
          chk("done_chan", 32'(done), 32'(1) << e.ch);
          chk("done_noerr", 32'(timeout_err), 0);
          chk("res_color", 32'(res_color), 32'(e.color));
          chk("res_shape", 32'(res_shape), 32'(e.shape));
          chk("done_after_oe", 32'(oe_q), 1);
          last_done = e;
        end
      end
    end
  end

  task automatic wait_out();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done != 0 || timeout_err) return;
    end
    checks++; errors++;
    $display("FAIL outcome_wait: no done or timeout_err within 200 cycles");
  endtask

  task automatic wait_grant();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (grant != 0) return;
    end
    checks++; errors++;
    $display("FAIL grant_wait: no grant within 50 cycles");
  endtask

  // Returns on the first WAIT cycle (start just fell).
  task automatic wait_fall();
    int n;
    n = 0;
    while (!bm_start && n < 50) begin @(negedge clk); n++; end
    while (bm_start && n < 600) begin @(negedge clk); n++; end
    if (n >= 600 || !bm_E) begin
      checks++; errors++;
      $display("FAIL start_fall_wait: start never completed its dwell");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v, prev;
    logic [3:0] mask;
    req = '0; dist_in = '0; mode_in = '0; stat_sel = '0;
    repeat (3) @(negedge clk);

    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_color", 32'(res_color), 0);
    chk("rst_shape", 32'(res_shape), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_dist", 32'(bm_dist), 0);
    chk("rst_mode", 32'(bm_mode), 0);
    chk("rst_start", 32'(bm_start), 0);
    chk("rst_E", 32'(bm_E), 0);
    chk("rst_stat", 32'(stat_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on channel 0
    dist_in[6:0] = 7'd12; mode_in[0] = 1'b0; oe_delay = 3;
    req = 4'b0001;
    sb.push_back(mk(0, pick(req)));
    wait_grant();
    chk("grant_load", 32'(grant), 32'b0001);
    chk("start_in_load", 32'(bm_start), 0);
    n = 0;
    @(negedge clk);
    while (bm_start && n < 300) begin
      if (n == 0) chk("bm_dist_run", 32'(bm_dist), 12);
      chk("bm_E_run", 32'(bm_E), 1);
      n++;
      @(negedge clk);
    end
    chk("dwell_len", n, 8);
    wait_out();
    req = '0;
    @(negedge clk);

    // Contention: all channels held
    dist_in = 28'($urandom); mode_in = 4'($urandom); oe_delay = 1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) sb.push_back(mk(0, pick(4'b1111)));
    for (int i = 0; i < 5; i++) wait_out();
    req = '0;
    @(negedge clk);

    // Timeout on channel 2, then channel 3 wins the next contest
    oe_delay = -1;
    req = 4'b0100;
    sb.push_back(mk(1, pick(req)));
    wait_grant();
    wait_fall();
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clk); n++; end
    chk("tmo_latency", n, 32);
    chk("tmo_no_done", 32'(done), 0);
    req = '0;
    @(negedge clk);
    oe_delay = 2;
    req = 4'b1100;
    sb.push_back(mk(0, pick(req)));
    wait_grant();
    chk("grant_after_tmo", 32'(grant), 32'b1000);
    wait_out();
    req = '0;
    @(negedge clk);

    // Live distance tracking on channel 2
    dist_in[2*DW +: DW] = 7'd12; mode_in[2] = 1'b1; oe_delay = 3;
    req = 4'b0100;
    void'(pick(req));
    wait_grant();
    v = 12; prev = 12;
    @(negedge clk);
    while (bm_start) begin
      chk("live_dist", 32'(bm_dist), prev);
      chk("live_mode", 32'(bm_mode), 1);
      v--; prev = v;
      dist_in[2*DW +: DW] = 7'(v);
      @(negedge clk);
    end
    sb.push_back(mk(0, 2));
    wait_out();
    req = '0;
    @(negedge clk);

    // Withdrawal mid-RUN on channel 1
    oe_delay = 1;
    req = 4'b0010;
    void'(pick(req));
    wait_grant();
    repeat (3) @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("abort_grant", 32'(grant), 0);
    chk("abort_start", 32'(bm_start), 0);
    chk("abort_E", 32'(bm_E), 0);
    repeat (5) @(negedge clk);
    chk("abort_res_color", 32'(res_color), 32'(last_done.color));
    chk("abort_res_shape", 32'(res_shape), 32'(last_done.shape));

    // Reset in the middle of WAIT
    oe_delay = -1;
    req = 4'b0001;
    void'(pick(req));
    wait_grant();
    wait_fall();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(bm_start), 0);
    chk("arst_E", 32'(bm_E), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_res", 32'(res_shape), 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    @(negedge clk);
    dist_in = 28'($urandom); mode_in = 4'($urandom); oe_delay = 0;
    req = 4'b1111;
    sb.push_back(mk(0, pick(req)));
    wait_grant();
    chk("ptr_after_reset", 32'(grant), 32'b0001);
    wait_out();
    req = '0;

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      dist_in  = 28'($urandom);
      mode_in  = 4'($urandom);
      mask     = 4'($urandom_range(1, 15));
      oe_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      sb.push_back(mk(oe_delay < 0, pick(mask)));
      req = mask;
      wait_out();
      req = '0;
    end
    @(negedge clk);

`ifdef BRAIN_M_SCHED_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    @(negedge clk);
    for (int i = 0; i < 302; i++) begin
      oe_delay = (i < 300) ? 0 : -1;
      req = 4'b0001;
      sb.push_back(mk(i >= 300, pick(req)));
      wait_out();
      req = '0;
      @(negedge clk);
    end
    stat_sel = 3'd0;
    #1 chk("stat_ch0", 32'(stat_cnt), 32'h02FF);
    stat_sel = 3'd1;
    #1 chk("stat_ch1", 32'(stat_cnt), 0);
    stat_sel = 3'd5;
    #1 chk("stat_sel_oob", 32'(stat_cnt), 0);
`else
    stat_sel = 3'd0;
    #1 chk("stat_off_sel0", 32'(stat_cnt), 0);
    stat_sel = 3'd2;
    #1 chk("stat_off_sel2", 32'(stat_cnt), 0);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
